rr_arb64_idx: RTL and testbench
===============================

# rr_arb64_idx

- Round-robin arbiter over 64 request lines.
- Issues one registered 6-bit grant index per accepted transfer, using a valid/ready handshake.
- Sits directly upstream of the 6-to-64 decoder: `gnt_idx` drives the decoder select, and the decoder's one-hot output becomes the per-channel grant strobe.
- Channel `i` corresponds to `req` bit `i` and to index value `i`.

## Interface
Parameters:
- `IDX_W`, default 6: index width; the channel count is 2^IDX_W = 64. Only 6 is supported.
- `BURST_LEN`, default 4: maximum consecutive accepted grants to one channel. Used only with `RR_ARB_BURST_EN`; legal range 1..16.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: arbitration enable. When low, no new grant is issued; a pending grant is held.
- `req` in 64: level request per channel.
- `gnt_ready` in 1: consumer accepts the current grant.
- `gnt_valid` out 1: `gnt_idx` holds a valid grant.
- `gnt_idx` out 6: index of the granted channel.
- `ptr` out 6: current round-robin priority pointer (debug/observe).

## Operation
- FSM has two states:
  - IDLE: `gnt_valid` = 0.
  - GRANT: `gnt_valid` = 1.
- IDLE → GRANT when `en` = 1 and `req` ≠ 0. The winner is registered into `gnt_idx`.
- Winner selection: the first set bit of `req` searching upward from `ptr`, wrapping from 63 to 0. `ptr` itself has the highest priority.
- GRANT with `gnt_ready` = 0: hold. `gnt_idx` and `gnt_valid` stay stable even if `req[gnt_idx]` drops or `en` drops. A grant is never withdrawn.
- GRANT with `gnt_ready` = 1 (accept):
  - `ptr` ← `gnt_idx` + 1, modulo 64, wrapping from 63 to 0.
  - Re-arbitrate in the same cycle using the updated pointer and the current `req`, with `en` = 1.
  - If there is a winner, stay in GRANT with the new `gnt_idx` (back-to-back; no bubble).
  - Otherwise go to IDLE. `gnt_idx` keeps its last value.
- `ptr` changes only on accept.
- All 64 bits of `req` are eligible; there is no masking.

## Timing
- Reset values: `gnt_valid` = 0, `gnt_idx` = 0, `ptr` = 0, FSM = IDLE, burst count = 0.
- Latency: `req` sampled high at edge t while idle → `gnt_valid` = 1 after edge t. Visible in the cycle after the request cycle.
- Throughput: one grant per cycle while `gnt_ready` = 1 and requests remain.
- The handshake completes on a rising edge where `gnt_valid` & `gnt_ready` = 1.
- `gnt_ready` without `gnt_valid` has no effect.
- Simultaneous accept and `en` = 0: the accept completes and `ptr` advances, then the FSM goes to IDLE with no new grant.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). The pending grant is lost, with no completion.

## Configuration
- Macro `RR_ARB_BURST_EN`.
- Defined: a 4-bit burst counter is compiled in.
  - On accept, if `req[gnt_idx]` = 1 and count < `BURST_LEN`−1: re-grant the same index, count++, `ptr` unchanged.
  - Otherwise rotate as normal and clear the count.
  - The count also clears on entry to IDLE.
- Not defined: the counter is absent and `BURST_LEN` is ignored. Every accept rotates `ptr`, giving strictly one transfer per grant.

## Structure
- Shared package `rr_arb_pkg`:
  - `IDX_W` and `NCH` = 64 constants.
  - FSM state typedef (IDLE, GRANT).
  - `BURST_CNT_W` = 4.
- One sub-module, `rr_pick64`: purely combinational wrap-around first-one search.
  - Inputs: `req`[64] and `ptr`[6].
  - Outputs: `found`[1] and `idx`[6].
  - Implemented by rotating `req` right by `ptr`, running a priority encoder, then adding `ptr` back modulo 64.
- The top level holds the FSM, the pointer, the burst counter, and the output registers.

## Test plan
- Reset with `req` = all ones → `gnt_valid` = 0, `gnt_idx` = 0, `ptr` = 0. After release with `en` = 1 and `gnt_ready` = 1: grants 0, 1, 2, …, 63, 0 on consecutive cycles.
- `req` = bits {5, 40}, `ptr` = 0, `gnt_ready` = 1:
  - Grants alternate 5, 40, 5, 40.
  - After the accept of 40, `ptr` = 41. Wrap-around picks 5.
- Hold check: grant idx 12 with `gnt_ready` = 0 for 3 cycles while `req[12]` drops and `en` drops → `gnt_idx` = 12 and `gnt_valid` = 1 are stable. Then `gnt_ready` = 1 → IDLE next cycle, `ptr` = 13.
- `req` = bit 63 only → `gnt_idx` = 63. Accept → `ptr` = 0 (wrap). With `req` still 63 → re-grant 63 back-to-back.
- With `RR_ARB_BURST_EN`, `BURST_LEN` = 4, `req` = {2, 3}, ready held high → sequence 2, 2, 2, 2, 3, 3, 3, 3, 2. Without the macro → 2, 3, 2, 3.
- Assert `rst_n` low mid-GRANT at idx 30 → `gnt_valid` goes to 0 before the next edge, and `ptr` = 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 64-channel round-robin index arbiter.
package rr_arb_pkg;

  localparam int IDX_W       = 6;
  localparam int NCH         = 64;
  localparam int BURST_CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb64_idx_pick.sv
// rr_pick64: combinational wrap-around first-one search over 64 requests.
// The request vector is rotated right by ptr so that ptr lands on bit 0. A
// lowest-bit-first priority encoder then runs, and ptr is added back
// modulo 64 to recover the absolute channel index.
module rr_pick64
  import rr_arb_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0]   req_rot;
  logic [IDX_W-1:0] pos;

  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NCH-1:0];

  // Priority encoder: the lowest set bit of the rotated vector wins.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pos   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // The 6-bit sum wraps naturally from 63 back to 0.
  assign idx = pos + ptr;

endmodule

// File: rtl/rr_arb64_idx.sv
// rr_arb64_idx: round-robin arbiter over 64 level requests. It issues a
// registered 6-bit grant index per accepted transfer over a valid/ready
// handshake, and its output drives a 6-to-64 decoder select.
// Optional build macro RR_ARB_BURST_EN adds a burst counter. With the
// counter, up to BURST_LEN consecutive accepted grants can go to the same
// channel before the pointer rotates.
module rr_arb64_idx
  import rr_arb_pkg::*;
#(
  parameter int IDX_W     = 6,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [(2**IDX_W)-1:0]   req,
  input  logic                    gnt_ready,
  output logic                    gnt_valid,
  output logic [IDX_W-1:0]        gnt_idx,
  output logic [IDX_W-1:0]        ptr
);

  if (IDX_W != 6 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_cfg
    $error("rr_arb64_idx: IDX_W must be 6 and BURST_LEN must be 1..16");
  end

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             regrant;

  assign ptr_inc = gnt_idx + IDX_W'(1);

  // While a grant is outstanding, arbitration looks ahead from the pointer
  // value that an accept would commit. This makes back-to-back grants use
  // the updated priority in the same cycle.
  assign pick_ptr = (state == GRANT) ? ptr_inc : ptr;

  rr_pick64 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RR_ARB_BURST_EN
  logic [BURST_CNT_W-1:0] cnt, cnt_nxt;

  assign regrant = en && req[gnt_idx] && (cnt < BURST_CNT_W'(BURST_LEN - 1));

  // Burst counter: counts extra same-channel grants since the last rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  assign regrant = 1'b0;
`endif

  // State, pointer and grant-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= idx_nxt;
    end
  end

  // Next-state logic. A grant is held until accepted. On accept the
  // pointer moves past the granted channel (or stays put for a burst
  // re-grant), and the next winner is loaded with no idle bubble.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
`ifdef RR_ARB_BURST_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: begin
`ifdef RR_ARB_BURST_EN
        cnt_nxt = '0;
`endif
        if (en && pick_found) begin
          state_nxt = GRANT;
          idx_nxt   = pick_idx;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          if (regrant) begin
`ifdef RR_ARB_BURST_EN
            cnt_nxt = cnt + BURST_CNT_W'(1);
`endif
          end else begin
`ifdef RR_ARB_BURST_EN
            cnt_nxt = '0;
`endif
            ptr_nxt = ptr_inc;
            if (en && pick_found) begin
              idx_nxt = pick_idx;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_arb64_idx.sv
// Testbench for rr_arb64_idx: directed scenarios followed by randomized
// traffic. All traffic is checked every cycle against a behavioural model.
module tb_rr_arb64_idx;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [63:0] req = '0;
  logic        gnt_ready = 1'b0;
  logic        gnt_valid;
  logic [5:0]  gnt_idx;
  logic [5:0]  ptr;

  rr_arb64_idx #(.IDX_W(6), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_cnt;

  logic [63:0] rr;
  bit          re, rd;
  int          exp_seq[9];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // The first requesting channel at or after p, going upward and wrapping.
  function automatic int pick(input logic [63:0] r, input int p);
    for (int k = 0; k < 64; k++) begin
      if (r[(p + k) % 64]) return (p + k) % 64;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    int  w;
    bit  again;
    again = 1'b0;
    if (!m_valid) begin
      m_cnt = 0;
      w = pick(req, m_ptr);
      if (en && w >= 0) begin
        m_valid = 1'b1;
        m_idx   = w;
      end
    end else if (gnt_ready) begin
`ifdef RR_ARB_BURST_EN
      again = en && req[m_idx] && (m_cnt < BL - 1);
`endif
      if (again) begin
        m_cnt++;
      end else begin
        m_cnt = 0;
        m_ptr = (m_idx + 1) % 64;
        w = pick(req, m_ptr);
        if (en && w >= 0) m_idx = w;
        else m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("valid", {31'd0, gnt_valid}, int'(m_valid));
    chk("idx", {26'd0, gnt_idx}, m_idx);
    chk("ptr", {26'd0, ptr}, m_ptr);
  endtask

  task automatic cyc(input bit e, input logic [63:0] r, input bit rdy);
    en        = e;
    req       = r;
    gnt_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic [63:0] r);
    rst_n     = 1'b0;
    en        = 1'b1;
    gnt_ready = 1'b1;
    req       = r;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, gnt_valid}, 0);
    chk("rst_idx", {26'd0, gnt_idx}, 0);
    chk("rst_ptr", {26'd0, ptr}, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with all requests high, then a full rotation 0..63, 0
    do_reset({64{1'b1}});
    for (int n = 1; n <= 65; n++) begin
      cyc(1'b1, {64{1'b1}}, 1'b1);
`ifndef RR_ARB_BURST_EN
      chk("seq_all", {26'd0, gnt_idx}, (n - 1) % 64);
`endif
    end

    // Two requesters {5, 40} alternate, with wrap-around from ptr 41
    do_reset('0);
    rr = (64'd1 << 5) | (64'd1 << 40);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1, rr, 1'b1);
`ifndef RR_ARB_BURST_EN
      chk("seq_5_40", {26'd0, gnt_idx}, (n % 2 == 0) ? 5 : 40);
      if (n == 2) chk("ptr_after_40", {26'd0, ptr}, 41);
`endif
    end

    // Hold: grant 12 stays while ready=0, even as req and en drop
    do_reset('0);
    cyc(1'b1, 64'd1 << 12, 1'b0);
    chk("hold_first", {26'd0, gnt_idx}, 12);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, '0, 1'b0);
      chk("hold_idx", {26'd0, gnt_idx}, 12);
      chk("hold_valid", {31'd0, gnt_valid}, 1);
    end
    cyc(1'b0, '0, 1'b1);
    chk("hold_release_valid", {31'd0, gnt_valid}, 0);
    chk("hold_release_ptr", {26'd0, ptr}, 13);

    // Channel 63 only: pointer wraps to 0, and 63 is re-granted back-to-back
    cyc(1'b1, 64'd1 << 63, 1'b0);
    chk("top_idx", {26'd0, gnt_idx}, 63);
    cyc(1'b1, 64'd1 << 63, 1'b1);
    chk("top_regrant", {26'd0, gnt_idx}, 63);
    chk("top_regrant_valid", {31'd0, gnt_valid}, 1);
`ifndef RR_ARB_BURST_EN
    chk("top_ptr_wrap", {26'd0, ptr}, 0);
`endif

    // Burst behaviour with requests {2, 3}
`ifdef RR_ARB_BURST_EN
    exp_seq = '{2, 2, 2, 2, 3, 3, 3, 3, 2};
`else
    exp_seq = '{2, 3, 2, 3, 2, 3, 2, 3, 2};
`endif
    do_reset('0);
    rr = (64'd1 << 2) | (64'd1 << 3);
    for (int n = 0; n < 9; n++) begin
      cyc(1'b1, rr, 1'b1);
      chk("burst_seq", {26'd0, gnt_idx}, exp_seq[n]);
    end

    // Asynchronous reset in the middle of a grant at index 30
    do_reset('0);
    cyc(1'b1, 64'd1 << 29, 1'b0);
    cyc(1'b1, 64'd1 << 30, 1'b1);
    chk("pre_rst_idx", {26'd0, gnt_idx}, 30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, gnt_valid}, 0);
    chk("async_rst_ptr", {26'd0, ptr}, 0);
    chk("async_rst_idx", {26'd0, gnt_idx}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      case ($urandom % 4)
        0: rr = '0;
        1: rr = 64'd1 << ($urandom % 64);
        2: rr = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: rr = {$urandom, $urandom};
      endcase
      re = ($urandom % 4) != 0;
      rd = ($urandom % 3) != 0;
      cyc(re, rr, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
